// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch buffer between the program counter and decode.
//
// Each accepted fetch stores the {pc, instruction} pair in a small circular
// FIFO. The head entry is presented to decode with a valid/ready handshake.
// fetch_ready is registered back-pressure: low only when every slot is
// occupied, so upstream holds the PC. flush (branch/jump redirect) and reset
// both empty the queue and return the pointers to zero on the next edge.
//
// Optional feature (macro FETCH_BYPASS_EN): when the queue is empty, a valid
// fetch is shown on dec_* in the same cycle. If decode takes it in that cycle,
// it is never written into the queue.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-high; overrides every other input
//   fetch_valid  in   fetch_pc/imem_rdata carry a valid fetch this cycle
//   fetch_pc     in   [31:0] PC of the fetched instruction
//   imem_rdata   in   [31:0] instruction word at fetch_pc
//   fetch_ready  out  queue can accept a push
//   flush        in   discard all buffered entries
//   dec_ready    in   decode accepts the head entry
//   dec_valid    out  head entry valid
//   dec_instr    out  [31:0] head instruction (0 when nothing valid)
//   dec_pc       out  [31:0] head PC (0 when nothing valid)
//   dec_pc_plus4 out  [31:0] dec_pc + 4, wrapping modulo 2^32
//   count        out  [PTR_W:0] occupied entries, 0..DEPTH

module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_valid,
    input  logic [31:0]      fetch_pc,
    input  logic [31:0]      imem_rdata,
    output logic             fetch_ready,
    input  logic             flush,
    input  logic             dec_ready,
    output logic             dec_valid,
    output logic [31:0]      dec_instr,
    output logic [31:0]      dec_pc,
    output logic [31:0]      dec_pc_plus4,
    output logic [PTR_W:0]   count
);

    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);

    logic [31:0]      mem_pc    [DEPTH];
    logic [31:0]      mem_instr [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == DepthCnt);
    end

    assign fetch_ready = ~full;
    assign count       = count_q;

`ifdef FETCH_BYPASS_EN
    logic bypass;

    // An empty queue forwards the live fetch straight to decode.
    assign bypass = empty & fetch_valid & ~flush;

    always_comb begin
        dec_valid = ~empty | bypass;
        dec_instr = '0;
        dec_pc    = '0;
        if (!empty) begin
            dec_instr = mem_instr[rd_ptr_q];
            dec_pc    = mem_pc[rd_ptr_q];
        end else if (bypass) begin
            dec_instr = imem_rdata;
            dec_pc    = fetch_pc;
        end
    end

    // A bypassed entry taken by decode this cycle is never stored.
    assign push = fetch_valid & fetch_ready & ~flush & ~(bypass & dec_ready);
    assign pop  = ~empty & dec_ready & ~flush;
`else
    always_comb begin
        dec_valid = ~empty;
        dec_instr = '0;
        dec_pc    = '0;
        if (!empty) begin
            dec_instr = mem_instr[rd_ptr_q];
            dec_pc    = mem_pc[rd_ptr_q];
        end
    end

    assign push = fetch_valid & fetch_ready & ~flush;
    assign pop  = dec_valid & dec_ready & ~flush;
`endif

    assign dec_pc_plus4 = dec_pc + 32'd4;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_pc[wr_ptr_q]    <= fetch_pc;
            mem_instr[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule
